// File: rtl/vidac_pkg.sv
// Shared definitions for the line-accelerator command-list writer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package vidac_pkg;

  localparam logic [7:0]  OP_END       = 8'h00;
  localparam logic [7:0]  OP_LINE      = 8'h01;
  localparam int          REC_LEN      = 10;
  localparam logic [16:0] BASE_DEFAULT = 17'h10000;

  // CPU register map (indices 0..8 are the staging bytes)
  localparam logic [3:0] IDX_STG_LAST = 4'd8;
  localparam logic [3:0] IDX_COMMIT   = 4'd9;
  localparam logic [3:0] IDX_FLUSH    = 4'd10;
  localparam logic [3:0] IDX_CLR_OVF  = 4'd11;

  // One staged LINE command; x1 sits in the low bits so bytes leave LSB-first.
  typedef struct packed {
    logic [7:0]  colour;
    logic [15:0] y2;
    logic [15:0] x2;
    logic [15:0] y1;
    logic [15:0] x1;
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_TERM,
    ST_KICK,
    ST_WAITE
  } state_t;

endpackage

// File: rtl/vidac_feed_fifo.sv
// Synchronous FIFO holding committed LINE commands.
// Latency: head visible the cycle after push; full/empty update the cycle after push/pop.
// Backpressure: push while full is dropped (even with a same-cycle pop); pop while empty ignored.
// Ports: clock/reset_n; push/push_dat in; pop in, pop_dat = current head; full/empty status.
module vidac_feed_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/vidac_feed.sv
// Queues CPU LINE commands and serializes them as 10-byte records plus terminator into video memory, then kicks the accelerator.
// Latency: first byte in the first gnt cycle after the IDLE decision; n records = 10n+1 write cycles, cmd the cycle after.
// Backpressure: gnt=0 stalls writes in place; bsy holds off new batches; commit while full is dropped and sets ovf.
// Ports: clock/reset_n; CPU side cpu_we/cpu_a/cpu_d; status full/empty/active/ovf;
//        memory side a/o/w with gnt; accelerator side cmd/bsy.
// Build option: VIDAC_FEED_AUTOKICK_EN starts a batch whenever the FIFO is non-empty (flush becomes a no-op).
module vidac_feed
  import vidac_pkg::*;
#(
  parameter int          DEPTH = 4,
  parameter logic [16:0] BASE  = BASE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_a,
  input  logic [7:0]  cpu_d,
  output logic        full,
  output logic        empty,
  output logic        active,
  output logic        ovf,
  output logic [16:0] a,
  output logic [7:0]  o,
  output logic        w,
  input  logic        gnt,
  output logic        cmd,
  input  logic        bsy
);

  localparam int NW = $clog2(DEPTH + 1);

  state_t       state_q, state_d;
  logic [7:0]   stg_q [9];
  logic [7:0]   stg_d [9];
  logic [79:0]  sr_q, sr_d;
  logic [16:0]  a_q, a_d;
  logic [NW-1:0] n_q, n_d;
  logic [3:0]   byte_q, byte_d;
  logic         kick_pend_q, kick_pend_d;
  logic         ovf_q, ovf_d;

  line_t        stg_word;
  logic [71:0]  head;
  logic         commit, push, pop, start_ok;

  assign stg_word = {stg_q[8], stg_q[7], stg_q[6], stg_q[5], stg_q[4],
                     stg_q[3], stg_q[2], stg_q[1], stg_q[0]};
  assign commit   = cpu_we && (cpu_a == IDX_COMMIT);
  assign push     = commit && !full;

  vidac_feed_fifo #(
    .WIDTH (72),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (stg_word),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

`ifdef VIDAC_FEED_AUTOKICK_EN
  assign start_ok = !empty && !bsy;
`else
  assign start_ok = kick_pend_q && !empty && !bsy;
`endif

  assign a      = a_q;
  assign ovf    = ovf_q;
  assign active = (state_q != ST_IDLE);

  always_comb begin
    stg_d       = stg_q;
    state_d     = state_q;
    sr_d        = sr_q;
    a_d         = a_q;
    n_d         = n_q;
    byte_d      = byte_q;
    kick_pend_d = kick_pend_q;
    ovf_d       = ovf_q;
    pop         = 1'b0;
    w           = 1'b0;
    o           = 8'h00;
    cmd         = 1'b0;

    if (cpu_we && (cpu_a <= IDX_STG_LAST)) stg_d[cpu_a] = cpu_d;
    if (commit && full) ovf_d = 1'b1;
    if (cpu_we && (cpu_a == IDX_CLR_OVF)) ovf_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          pop         = 1'b1;
          sr_d        = {head, OP_LINE};
          n_d         = NW'(1);
          byte_d      = '0;
          a_d         = BASE;
          kick_pend_d = 1'b0;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (gnt) begin
          w    = 1'b1;
          o    = sr_q[7:0];
          sr_d = sr_q >> 8;
          a_d  = a_q + 17'd1;
          if (byte_q == 4'(REC_LEN - 1)) begin
            byte_d = '0;
            // Chain queued entries into this batch until it holds DEPTH records.
            if (!empty && (n_q < NW'(DEPTH))) begin
              pop  = 1'b1;
              sr_d = {head, OP_LINE};
              n_d  = n_q + NW'(1);
            end else begin
              state_d = ST_TERM;
            end
          end else begin
            byte_d = byte_q + 4'd1;
          end
        end
      end
      ST_TERM: begin
        if (gnt) begin
          w       = 1'b1;
          o       = OP_END;
          state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        cmd = 1'b1;
        if (bsy) state_d = ST_WAITE;
      end
      ST_WAITE: begin
        if (!bsy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifndef VIDAC_FEED_AUTOKICK_EN
    // Evaluated after the IDLE clear so a flush in the start cycle is not lost.
    if (cpu_we && (cpu_a == IDX_FLUSH) && !empty) kick_pend_d = 1'b1;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 9; i++) stg_q[i] <= 8'h00;
      sr_q        <= '0;
      a_q         <= BASE;
      n_q         <= '0;
      byte_q      <= '0;
      kick_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stg_q       <= stg_d;
      sr_q        <= sr_d;
      a_q         <= a_d;
      n_q         <= n_d;
      byte_q      <= byte_d;
      kick_pend_q <= kick_pend_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vidac_feed.sv
// Directed, table-driven bench for vidac_feed with a video-memory write log and a bsy model.
module tb_vidac_feed;
  import vidac_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_a = 4'd0;
  logic [7:0]  cpu_d = 8'd0;
  logic        full, empty, active, ovf, w, cmd;
  logic [16:0] a;
  logic [7:0]  o;
  logic        gnt = 1'b0;
  logic        bsy = 1'b0;

  vidac_feed dut (
    .clock(clock), .reset_n(reset_n), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .full(full), .empty(empty), .active(active), .ovf(ovf),
    .a(a), .o(o), .w(w), .gnt(gnt), .cmd(cmd), .bsy(bsy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  dat;
    int          cyc;
  } wr_t;

  typedef struct {
    logic       we;
    logic [3:0] idx;
    logic [7:0] d;
    logic [3:0] exp;   // {full, empty, ovf, active}
  } vec_t;

  wr_t  wlog[$];
  int   cyc = 0;
  int   cmd_cnt = 0, cmd_rise = -1;
  logic cmd_prev = 1'b0;
  int   hold_n = 0, hold_err = 0;
  logic prev_ok = 1'b0, prev_gnt = 1'b0, prev_act = 1'b0;
  logic [16:0] prev_a = '0;

  logic bsy_auto = 1'b0, arm = 1'b0, gnt_toggle = 1'b0;
  int   bsy_cnt = 0;

  int checks = 0, errors = 0;

  always @(posedge clock) cyc++;

  // All DUT observation happens on the falling edge.
  always @(negedge clock) begin
    if (w) wlog.push_back('{a, o, cyc});
    if (cmd) begin
      cmd_cnt++;
      if (!cmd_prev) cmd_rise = cyc;
    end
    cmd_prev = cmd;
    if (prev_ok && !prev_gnt && prev_act) begin
      hold_n++;
      if (a !== prev_a) hold_err++;
    end
    prev_ok  = 1'b1;
    prev_gnt = gnt;
    prev_act = active;
    prev_a   = a;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; inputs change 1 time unit after the edge. The bsy model raises
  // bsy one cycle after cmd is seen and drops it 50 cycles later.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bsy_auto) begin
      if (bsy_cnt > 0) begin
        bsy_cnt--;
        if (bsy_cnt == 0) bsy = 1'b0;
      end else if (arm) begin
        bsy = 1'b1;
        bsy_cnt = 50;
        arm = 1'b0;
      end else if (cmd && !bsy) begin
        arm = 1'b1;
      end
    end
    if (gnt_toggle) gnt = !gnt;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [7:0] d);
    cpu_we = 1'b1; cpu_a = idx; cpu_d = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic stage(input logic [15:0] x1, input logic [15:0] y1,
                       input logic [15:0] x2, input logic [15:0] y2, input logic [7:0] c);
    wr(4'd0, x1[7:0]); wr(4'd1, x1[15:8]);
    wr(4'd2, y1[7:0]); wr(4'd3, y1[15:8]);
    wr(4'd4, x2[7:0]); wr(4'd5, x2[15:8]);
    wr(4'd6, y2[7:0]); wr(4'd7, y2[15:8]);
    wr(4'd8, c);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_we = 1'b0; gnt = 1'b0; bsy = 1'b0;
    bsy_auto = 1'b0; arm = 1'b0; bsy_cnt = 0; gnt_toggle = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    wlog.delete();
    cmd_cnt = 0; cmd_rise = -1; hold_n = 0; hold_err = 0;
  endtask

  task automatic wait_batches(input int nbytes, input int limit, input string name);
    int i;
    for (i = 0; i < limit; i++) begin
      tick();
      if (wlog.size() >= nbytes && !active && !bsy) break;
    end
    if (i == limit) begin
      checks++; errors++;
      $display("FAIL %s: timeout after %0d cycles, bytes=%0d", name, limit, wlog.size());
    end
  endtask

  vec_t vt[10];
  logic [7:0] exp1[11];
  int   n_at_reset, seq_err;
  logic seen_bsy;

  initial begin
    vt[0] = '{1'b1, 4'd0,  8'h11, 4'b0100};
    vt[1] = '{1'b0, 4'd9,  8'h00, 4'b0100};
    vt[2] = '{1'b1, 4'd9,  8'h00, 4'b0000};
    vt[3] = '{1'b1, 4'd9,  8'h00, 4'b0000};
    vt[4] = '{1'b1, 4'd9,  8'h00, 4'b0000};
    vt[5] = '{1'b1, 4'd9,  8'h00, 4'b1000};
    vt[6] = '{1'b1, 4'd9,  8'h55, 4'b1010};
    vt[7] = '{1'b1, 4'd12, 8'h00, 4'b1010};
    vt[8] = '{1'b1, 4'd11, 8'h00, 4'b1000};
    vt[9] = '{1'b1, 4'd10, 8'h00, 4'b1000};
    exp1 = '{8'h01, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h2C, 8'h01, 8'h96, 8'h00, 8'h0F, 8'h00};

    // Reset state
    do_reset();
    check("reset_state", {a, o, w, cmd, ovf, active, empty, full},
          {BASE_DEFAULT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

    // Register/FIFO table with the accelerator held busy
    bsy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_we = vt[i].we; cpu_a = vt[i].idx; cpu_d = vt[i].d;
      tick();
      cpu_we = 1'b0;
      check($sformatf("table_row%0d", i), {full, empty, ovf, active}, vt[i].exp);
    end
    // Release bsy: a full FIFO drains as one DEPTH-record batch.
    bsy = 1'b0; gnt = 1'b1; bsy_auto = 1'b1;
    wait_batches(41, 400, "depth_batch");
    check("depth_batch_len", wlog.size(), 41);
    if (wlog.size() == 41) begin
      check("depth_rec3_op", {wlog[30].addr, wlog[30].dat}, {BASE_DEFAULT + 17'd30, 8'h01});
      check("depth_rec3_x1l", wlog[31].dat, 8'h11);
      check("depth_term", {wlog[40].addr, wlog[40].dat}, {BASE_DEFAULT + 17'd40, 8'h00});
    end
    check("depth_empty", empty, 1'b1);

    // Single record, gnt tied high
    do_reset();
    gnt = 1'b1; bsy_auto = 1'b1;
    stage(16'd10, 16'd20, 16'd300, 16'd150, 8'h0F);
    wr(IDX_COMMIT, 8'h00);
    wr(IDX_FLUSH, 8'h00);
    wait_batches(11, 300, "single");
    check("single_len", wlog.size(), 11);
    if (wlog.size() == 11) begin
      for (int i = 0; i < 11; i++)
        check($sformatf("single_byte%0d", i), {wlog[i].addr, wlog[i].dat},
              {BASE_DEFAULT + 17'(i), exp1[i]});
      check("single_span", wlog[10].cyc - wlog[0].cyc, 10);
      check("single_cmd_rise", cmd_rise, wlog[10].cyc + 1);
    end
    check("single_cmd_len", cmd_cnt, 2);

    // Second batch queued while the accelerator runs
    do_reset();
    gnt = 1'b1; bsy_auto = 1'b1;
    stage(16'd1, 16'd2, 16'd3, 16'd4, 8'hA0);
    wr(IDX_COMMIT, 8'h00);
    wr(IDX_FLUSH, 8'h00);
    for (int i = 0; i < 100 && !cmd; i++) tick();
    wr(4'd8, 8'hB1);
    wr(IDX_COMMIT, 8'h00);
    wr(IDX_FLUSH, 8'h00);
    seen_bsy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bsy) seen_bsy = 1'b1;
      if (seen_bsy && !bsy) break;
    end
    check("busy_no_writes", {seen_bsy, 32'(wlog.size())}, {1'b1, 32'd11});
    wait_batches(22, 300, "second_batch");
    check("second_len", wlog.size(), 22);
    if (wlog.size() == 22) begin
      check("second_op", {wlog[11].addr, wlog[11].dat}, {BASE_DEFAULT, 8'h01});
      check("second_colour", wlog[20].dat, 8'hB1);
      check("second_term", {wlog[21].addr, wlog[21].dat}, {BASE_DEFAULT + 17'd10, 8'h00});
    end
    check("two_cmd_pulses", cmd_cnt, 4);

    // Three records with gnt toggling every cycle
    do_reset();
    bsy_auto = 1'b1;
    stage(16'd1, 16'd0, 16'd0, 16'd0, 8'h00);
    wr(IDX_COMMIT, 8'h00);
    wr(4'd0, 8'h02);
    wr(IDX_COMMIT, 8'h00);
    wr(4'd0, 8'h03);
    wr(IDX_COMMIT, 8'h00);
    wr(IDX_FLUSH, 8'h00);
    gnt_toggle = 1'b1;
    wait_batches(31, 500, "toggle");
    gnt_toggle = 1'b0;
    check("toggle_len", wlog.size(), 31);
    if (wlog.size() == 31) begin
      seq_err = 0;
      for (int i = 0; i < 31; i++) if (wlog[i].addr !== BASE_DEFAULT + 17'(i)) seq_err++;
      check("toggle_addr_seq", seq_err, 0);
      check("toggle_rec0_x1", wlog[1].dat, 8'h01);
      check("toggle_rec1_x1", wlog[11].dat, 8'h02);
      check("toggle_rec2_x1", wlog[21].dat, 8'h03);
      check("toggle_term", {wlog[30].addr, wlog[30].dat}, {BASE_DEFAULT + 17'd30, 8'h00});
      check("toggle_span", wlog[30].cyc - wlog[0].cyc, 60);
    end
    check("toggle_hold", {hold_n > 0, 32'(hold_err)}, {1'b1, 32'd0});

    // Asynchronous reset during byte 4 of the first record
    do_reset();
    gnt = 1'b1;
    stage(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h77);
    wr(IDX_COMMIT, 8'h00);
    wr(IDX_COMMIT, 8'h00);
    wr(IDX_FLUSH, 8'h00);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (w && a == BASE_DEFAULT + 17'd4) break;
    end
    check("pre_reset_w", {w, a}, {1'b1, BASE_DEFAULT + 17'd4});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_outs", {w, cmd}, 2'b00);
    n_at_reset = wlog.size();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    check("post_reset_state", {empty, active}, 2'b10);
    repeat (30) tick();
    check("post_reset_quiet", {32'(cmd_cnt), 32'(wlog.size())}, {32'd0, 32'(n_at_reset)});

    // Commit without flush
    do_reset();
    gnt = 1'b1; bsy_auto = 1'b1;
    stage(16'd5, 16'd6, 16'd7, 16'd8, 8'h09);
    wr(IDX_COMMIT, 8'h00);
    repeat (40) tick();
`ifdef VIDAC_FEED_AUTOKICK_EN
    check("autokick_batch", wlog.size(), 11);
`else
    check("no_flush_no_batch", {32'(wlog.size()), active, empty}, {32'd0, 1'b0, 1'b0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
